// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation controller for a bottom-plate CDAC.
// The sequence is sample, then for each bit MSB first: trial, then compare.
// Define SAR_CMP_TIMEOUT_EN to add the comparator timeout and the sticky
// tmo_err output. When it is undefined, COMPARE waits for comp_valid forever.
module sar_ctrl #(
  parameter int Ndac        = 16,
  parameter int SAMP_CYCLES = 4,
  parameter int TMO_CYCLES  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            comp_valid,
  input  logic            comp_out,
  output logic            comp_req,
  output logic            samp,
  output logic [Ndac-1:0] cap_botplate,
  output logic            busy,
  output logic [Ndac-1:0] result,
  output logic            result_valid
`ifdef SAR_CMP_TIMEOUT_EN
  ,
  output logic            tmo_err
`endif
);

  localparam int IW = $clog2(Ndac);
  localparam int SW = $clog2(SAMP_CYCLES + 1);
`ifdef SAR_CMP_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    TRIAL,
    COMPARE,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            samp_q, samp_d;
  logic            comp_req_q, comp_req_d;
  logic [Ndac-1:0] cap_q, cap_d;
  logic [Ndac-1:0] result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic            decide;
  logic            bitVal;
`ifdef SAR_CMP_TIMEOUT_EN
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            tmo_err_q, tmo_err_d;
`endif

  // State and output registers; an asserted reset aborts any conversion at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= IW'(Ndac - 1);
      cnt_q          <= '0;
      samp_q         <= 1'b0;
      comp_req_q     <= 1'b0;
      cap_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
`ifdef SAR_CMP_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      tmo_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      samp_q         <= samp_d;
      comp_req_q     <= comp_req_d;
      cap_q          <= cap_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
`ifdef SAR_CMP_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      tmo_err_q      <= tmo_err_d;
`endif
    end
  end

  // Next-state logic; outputs are computed here as next values so they come out registered
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    samp_d         = samp_q;
    comp_req_d     = comp_req_q;
    cap_d          = cap_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    decide         = 1'b0;
    bitVal         = 1'b0;
`ifdef SAR_CMP_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    tmo_err_d      = tmo_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          cap_d   = '0;
          samp_d  = 1'b1;
          cnt_d   = '0;
`ifdef SAR_CMP_TIMEOUT_EN
          tmo_err_d = 1'b0;
`endif
        end
      end
      SAMPLE: begin
        if (cnt_q == SW'(SAMP_CYCLES - 1)) begin
          state_d = TRIAL;
          samp_d  = 1'b0;
          idx_d   = IW'(Ndac - 1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      TRIAL: begin
        cap_d[idx_q] = 1'b1;
        comp_req_d   = 1'b1;
        state_d      = COMPARE;
`ifdef SAR_CMP_TIMEOUT_EN
        tmo_cnt_d    = '0;
`endif
      end
      COMPARE: begin
        if (comp_valid) begin
          decide = 1'b1;
          bitVal = comp_out;
        end
`ifdef SAR_CMP_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TMO_CYCLES - 1)) begin
          decide    = 1'b1;
          bitVal    = 1'b0;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
        if (decide) begin
          cap_d[idx_q] = bitVal;
          comp_req_d   = 1'b0;
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = TRIAL;
          end
        end
      end
      DONE: begin
        result_d       = cap_q;
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign comp_req     = comp_req_q;
  assign samp         = samp_q;
  assign cap_botplate = cap_q;
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
`ifdef SAR_CMP_TIMEOUT_EN
  assign tmo_err      = tmo_err_q;
`endif

endmodule
